// File: rtl/punc_controller.sv
// PUnC LC3 control FSM: fetch/decode/execute sequencing, datapath strobes, retired count.
// Ports: clk, rst (sync, active-high), ir, nzp_match in; datapath controls, halted, insn_count out.
// Build option PUNC_HALT_EN: TRAP enters a sticky HALT state (else TRAP is a NOP).
module punc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic             nzp_match,
  output logic             pc_ld,
  output logic             pc_clr,
  output logic             pc_inc,
  output logic [1:0]       pc_sel,
  output logic             ir_ld,
  output logic             ir_clr,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic [1:0]       dmem_r_addr_sel,
  output logic [1:0]       dmem_w_addr_sel,
  output logic [1:0]       rf_w_data_sel,
  output logic             rf_w_addr_sel,
  output logic             rf_w_wr,
  output logic             rf_rp_addr_sel,
  output logic             rf_rp_rd,
  output logic             rf_rq_rd,
  output logic             temp_ld,
  output logic             nzp_ld,
  output logic             nzp_clr,
  output logic [1:0]       alu_sel,
  output logic             alu_in_a_sel,
  output logic             halted,
  output logic [CNT_W-1:0] insn_count
);

  localparam logic [1:0] PC_8_0 = 2'd0, PC_10_0 = 2'd1, PC_RQ = 2'd2;
  localparam logic [1:0] RA_PC = 2'd0, RA_PC_8_0 = 2'd1;
  localparam logic [1:0] RA_RQ_5_0 = 2'd2, RA_RP = 2'd3;
  localparam logic [1:0] WA_PC_8_0 = 2'd0, WA_RQ_5_0 = 2'd1, WA_TEMP = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_PC_8_0 = 2'd1;
  localparam logic [1:0] WD_DMEM = 2'd2, WD_PC = 2'd3;
  localparam logic       WR_11_9 = 1'b0, WR_R7 = 1'b1;
  localparam logic       RP_11_9 = 1'b1;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd3;

  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2;
  localparam logic [3:0] OP_ST = 4'h3, OP_JSR = 4'h4, OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA, OP_STI = 4'hB, OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE, OP_TRAP = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT
  } state_t;

  state_t state, state_nxt;
  logic [3:0] op;
  logic       two_cyc;
  logic       retire;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign two_cyc   = (op == OP_LDI) || (op == OP_STI);
  assign retire    = (state == S_EXEC && !two_cyc) || state == S_EXEC2;
  assign unused_ir = ^{ir[10:6], ir[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      insn_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire)
        insn_count <= insn_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (two_cyc)
          state_nxt = S_EXEC2;
`ifdef PUNC_HALT_EN
        if (op == OP_TRAP)
          state_nxt = S_HALT;
`endif
      end
      S_EXEC2:  state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

`ifdef PUNC_HALT_EN
  assign halted = (state == S_HALT) && !rst;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    pc_ld = 1'b0; pc_clr = 1'b0; pc_inc = 1'b0; pc_sel = PC_8_0;
    ir_ld = 1'b0; ir_clr = 1'b0;
    dmem_rd = 1'b0; dmem_wr = 1'b0;
    dmem_r_addr_sel = RA_PC; dmem_w_addr_sel = WA_PC_8_0;
    rf_w_data_sel = WD_ALU; rf_w_addr_sel = WR_11_9; rf_w_wr = 1'b0;
    rf_rp_addr_sel = 1'b0; rf_rp_rd = 1'b0; rf_rq_rd = 1'b0;
    temp_ld = 1'b0; nzp_ld = 1'b0; nzp_clr = 1'b0;
    alu_sel = ALU_ADD; alu_in_a_sel = 1'b0;
    if (rst) begin
      pc_clr  = 1'b1;
      ir_clr  = 1'b1;
      nzp_clr = 1'b1;
    end else begin
      case (state)
        S_FETCH: begin
          dmem_rd = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_AND: begin
              alu_sel      = (op == OP_ADD) ? ALU_ADD : ALU_AND;
              alu_in_a_sel = ir[5];
              rf_w_wr      = 1'b1;
              nzp_ld       = 1'b1;
            end
            OP_NOT: begin
              alu_sel = ALU_NOT;
              rf_w_wr = 1'b1;
              nzp_ld  = 1'b1;
            end
            OP_LEA: begin
              rf_w_data_sel = WD_PC_8_0;
              rf_w_wr       = 1'b1;
              nzp_ld        = 1'b1;
            end
            OP_LD, OP_LDR, OP_LDI: begin
              dmem_rd         = 1'b1;
              dmem_r_addr_sel = RA_PC_8_0;
              rf_w_data_sel   = WD_DMEM;
              rf_w_wr         = 1'b1;
              // LDI's first read is only the pointer; flags follow the final value
              nzp_ld          = (op != OP_LDI);
              if (op == OP_LDR) begin
                dmem_r_addr_sel = RA_RQ_5_0;
                rf_rq_rd        = 1'b1;
              end
            end
            OP_ST: begin
              dmem_w_addr_sel = WA_PC_8_0;
              rf_rp_addr_sel  = RP_11_9;
              rf_rp_rd        = 1'b1;
              dmem_wr         = 1'b1;
            end
            OP_STR: begin
              dmem_w_addr_sel = WA_RQ_5_0;
              rf_rq_rd        = 1'b1;
              dmem_wr         = 1'b1;
            end
            OP_STI: begin
              dmem_rd         = 1'b1;
              dmem_r_addr_sel = RA_PC_8_0;
              temp_ld         = 1'b1;
            end
            OP_BR: begin
              pc_sel = PC_8_0;
              pc_ld  = nzp_match;
            end
            OP_JMP: begin
              pc_sel   = PC_RQ;
              rf_rq_rd = 1'b1;
              pc_ld    = 1'b1;
            end
            OP_JSR: begin
              // link write and jump share a cycle; JSRR R7 reads the old R7
              rf_w_addr_sel = WR_R7;
              rf_w_data_sel = WD_PC;
              rf_w_wr       = 1'b1;
              pc_ld         = 1'b1;
              pc_sel        = ir[11] ? PC_10_0 : PC_RQ;
              rf_rq_rd      = !ir[11];
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          rf_rp_addr_sel = RP_11_9;
          rf_rp_rd       = 1'b1;
          if (op == OP_LDI) begin
            dmem_rd         = 1'b1;
            dmem_r_addr_sel = RA_RP;
            rf_w_data_sel   = WD_DMEM;
            rf_w_wr         = 1'b1;
            nzp_ld          = 1'b1;
          end else begin
            dmem_w_addr_sel = WA_TEMP;
            dmem_wr         = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_controller.sv
// Directed-vector bench for punc_controller.
// Walks reset, ALU, branch, STI, JSRR, LDI, NOT and TRAP through the FSM.
module tb_punc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        nzp_match;
  logic        pc_ld, pc_clr, pc_inc, ir_ld, ir_clr;
  logic        dmem_rd, dmem_wr, rf_w_addr_sel, rf_w_wr;
  logic        rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
  logic        temp_ld, nzp_ld, nzp_clr, alu_in_a_sel, halted;
  logic [1:0]  pc_sel, dmem_r_addr_sel, dmem_w_addr_sel;
  logic [1:0]  rf_w_data_sel, alu_sel;
  logic [15:0] insn_count;
  logic [12:0] strobes;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign strobes = {pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, dmem_rd,
                    dmem_wr, rf_w_wr, rf_rp_rd, rf_rq_rd, temp_ld,
                    nzp_ld, nzp_clr};

  punc_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_match(nzp_match),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .dmem_r_addr_sel(dmem_r_addr_sel),
    .dmem_w_addr_sel(dmem_w_addr_sel), .rf_w_data_sel(rf_w_data_sel),
    .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
    .rf_rp_addr_sel(rf_rp_addr_sel), .rf_rp_rd(rf_rp_rd),
    .rf_rq_rd(rf_rq_rd), .temp_ld(temp_ld), .nzp_ld(nzp_ld),
    .nzp_clr(nzp_clr), .alu_sel(alu_sel), .alu_in_a_sel(alu_in_a_sel),
    .halted(halted), .insn_count(insn_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [15:0] insn);
    chk("fetch_ir_ld", ir_ld, 1);
    chk("fetch_pc_inc", pc_inc, 1);
    ir = insn;
    step();
    chk("decode_quiet", strobes, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    ir = 16'h0000;
    nzp_match = 1'b0;
    step();
    step();
    chk("rst_pc_clr", pc_clr, 1);
    chk("rst_ir_clr", ir_clr, 1);
    chk("rst_nzp_clr", nzp_clr, 1);
    chk("rst_strobes", strobes, 13'b0100100000001);
    chk("rst_halted", halted, 0);
    chk("rst_count", insn_count, 0);
    rst = 1'b0;
    #1;
    chk("fetch_rd", dmem_rd, 1);
    chk("fetch_raddr", dmem_r_addr_sel, 0);

    // ADD R1,R1,#-1
    fetch_decode(16'h127F);
    chk("add_a_imm", alu_in_a_sel, 1);
    chk("add_alu", alu_sel, 0);
    chk("add_wr", rf_w_wr, 1);
    chk("add_nzp", nzp_ld, 1);
    chk("add_cnt_pre", insn_count, 0);
    step();
    chk("add_cnt", insn_count, 1);

    // BRz #-3 not taken, then taken
    nzp_match = 1'b0;
    fetch_decode(16'h05FD);
    chk("br_nt_ld", pc_ld, 0);
    step();
    nzp_match = 1'b1;
    fetch_decode(16'h05FD);
    chk("br_t_ld", pc_ld, 1);
    chk("br_t_sel", pc_sel, 0);
    step();
    nzp_match = 1'b0;
    chk("br_cnt", insn_count, 3);

    // STI R2,#4
    fetch_decode(16'hB404);
    chk("sti_temp", temp_ld, 1);
    chk("sti_raddr", dmem_r_addr_sel, 1);
    chk("sti_no_wr", dmem_wr, 0);
    step();
    chk("sti2_wr", dmem_wr, 1);
    chk("sti2_waddr", dmem_w_addr_sel, 2);
    chk("sti2_rp", rf_rp_addr_sel, 1);
    chk("sti2_cnt_pre", insn_count, 3);
    step();
    chk("sti_back_fetch", ir_ld, 1);
    chk("sti_cnt", insn_count, 4);

    // JSRR R7
    fetch_decode(16'h41C0);
    chk("jsrr_wr", rf_w_wr, 1);
    chk("jsrr_waddr", rf_w_addr_sel, 1);
    chk("jsrr_wdata", rf_w_data_sel, 3);
    chk("jsrr_pc_ld", pc_ld, 1);
    chk("jsrr_pc_sel", pc_sel, 2);
    step();
    chk("jsrr_cnt", insn_count, 5);

    // LDI R3,#4
    fetch_decode(16'hA604);
    chk("ldi_wr", rf_w_wr, 1);
    chk("ldi_nzp", nzp_ld, 0);
    chk("ldi_raddr", dmem_r_addr_sel, 1);
    step();
    chk("ldi2_raddr", dmem_r_addr_sel, 3);
    chk("ldi2_wr", rf_w_wr, 1);
    chk("ldi2_nzp", nzp_ld, 1);
    step();
    chk("ldi_cnt", insn_count, 6);

    // NOT R3,R1
    fetch_decode(16'h967F);
    chk("not_alu", alu_sel, 3);
    chk("not_wr", rf_w_wr, 1);
    step();
    chk("not_cnt", insn_count, 7);

    // TRAP x25
    fetch_decode(16'hF025);
    chk("trap_exec_quiet", strobes, 0);
    step();
    chk("trap_cnt", insn_count, 8);
`ifdef PUNC_HALT_EN
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", halted, 1);
      chk("halt_quiet", strobes, 0);
      step();
    end
    chk("halt_cnt", insn_count, 8);
`else
    chk("trap_nop_halted", halted, 0);
    chk("trap_nop_fetch", ir_ld, 1);
`endif

    // reset mid-instruction
    ir = 16'h127F;
    step();
    rst = 1'b1;
    #1;
    chk("rst2_clr", strobes, 13'b0100100000001);
    step();
    chk("rst2_halted", halted, 0);
    chk("rst2_cnt", insn_count, 0);
    rst = 1'b0;
    #1;
    chk("rst2_fetch", ir_ld, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
